// File: rtl/cpu_fetchunit.sv
// Purpose : opcode fetch unit; one byte per access from instruction memory, presented with valid/ready
//           to the control unit, with redirect/flush and optional interrupt entry/return.
// Latency : opcode_valid rises the cycle after imem_ack; zero-wait memory yields one opcode per two cycles.
// Backpr. : opcode/pc hold while opcode_valid && !opcode_ready; no new imem_req is issued until consume or redirect.
// Ports   : clk, reset (sync, active-high); imem_req/imem_addr/imem_ack/imem_data (memory side);
//           opcode/opcode_valid/opcode_ready/pc (control side); redirect/redirect_addr (flush);
//           interrupt/iret/irq_ack/irq_active/epc (interrupt handshake).
// Config  : define CPU_FETCH_IRQ_EN to enable interrupt entry/return; undefined ties irq outputs to zero.
module cpu_fetchunit #(
  parameter logic [15:0] RESET_VECTOR = 16'h0000,
  parameter logic [15:0] IRQ_VECTOR   = 16'h0004
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [7:0]  imem_data,
  output logic [7:0]  opcode,
  output logic        opcode_valid,
  input  logic        opcode_ready,
  output logic [15:0] pc,
  input  logic        redirect,
  input  logic [15:0] redirect_addr,
  input  logic        interrupt,
  input  logic        iret,
  output logic        irq_ack,
  output logic        irq_active,
  output logic [15:0] epc
);

  typedef enum logic {S_REQ, S_HOLD} state_t;

  state_t      state_q, state_d;
  logic        run_q;
  logic [15:0] fetch_pc_q, fetch_pc_d;
  logic [15:0] req_addr_q, req_addr_d;
  logic [15:0] pc_q, pc_d;
  logic [7:0]  opcode_q, opcode_d;
  logic        valid_q, valid_d;
  logic        squash_q, squash_d;
  logic        consume;
  logic        take_irq;

  // run_q holds imem_req low for the first cycle out of reset, so a stale
  // ack from an access abandoned by reset can never be taken as data.
  assign imem_req     = (state_q == S_REQ) && run_q;
  // While a squashed access is outstanding the old address must stay on the
  // bus; fetch_pc already points at the redirect target.
  assign imem_addr    = squash_q ? req_addr_q : fetch_pc_q;
  assign opcode       = opcode_q;
  assign opcode_valid = valid_q;
  assign pc           = pc_q;
  assign consume      = valid_q && opcode_ready;

`ifdef CPU_FETCH_IRQ_EN
  logic        irq_ack_q, irq_active_q;
  logic [15:0] epc_q;

  // Interrupts are only taken at an instruction boundary, and never nested.
  assign take_irq = (state_q == S_HOLD) && (redirect || consume) && interrupt && !irq_active_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      irq_ack_q    <= 1'b0;
      irq_active_q <= 1'b0;
      epc_q        <= 16'h0000;
    end else begin
      irq_ack_q <= take_irq;
      if (take_irq) begin
        irq_active_q <= 1'b1;
        epc_q        <= redirect ? redirect_addr : fetch_pc_q;
      end else if (iret) begin
        irq_active_q <= 1'b0;
      end
    end
  end

  assign irq_ack    = irq_ack_q;
  assign irq_active = irq_active_q;
  assign epc        = epc_q;
`else
  logic unused_irq;
  assign unused_irq = interrupt | iret;
  assign take_irq   = 1'b0;
  assign irq_ack    = 1'b0;
  assign irq_active = 1'b0;
  assign epc        = 16'h0000;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_REQ;
      run_q      <= 1'b0;
      fetch_pc_q <= RESET_VECTOR;
      req_addr_q <= RESET_VECTOR;
      pc_q       <= RESET_VECTOR;
      opcode_q   <= 8'h00;
      valid_q    <= 1'b0;
      squash_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      run_q      <= 1'b1;
      fetch_pc_q <= fetch_pc_d;
      req_addr_q <= req_addr_d;
      pc_q       <= pc_d;
      opcode_q   <= opcode_d;
      valid_q    <= valid_d;
      squash_q   <= squash_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_addr_d = req_addr_q;
    pc_d       = pc_q;
    opcode_d   = opcode_q;
    valid_d    = valid_q;
    squash_d   = squash_q;
    case (state_q)
      S_REQ: begin
        if (imem_req) begin
          if (imem_ack) begin
            if (squash_q || redirect) begin
              // Data belongs to a flushed stream: drop it and refetch.
              squash_d = 1'b0;
              if (redirect) fetch_pc_d = redirect_addr;
            end else begin
              opcode_d   = imem_data;
              pc_d       = fetch_pc_q;
              fetch_pc_d = fetch_pc_q + 16'd1;
              valid_d    = 1'b1;
              state_d    = S_HOLD;
            end
          end else if (redirect) begin
            fetch_pc_d = redirect_addr;
            // Only the first redirect captures the in-flight address.
            if (!squash_q) begin
              squash_d   = 1'b1;
              req_addr_d = fetch_pc_q;
            end
          end
        end else if (redirect) begin
          fetch_pc_d = redirect_addr;
        end
      end
      S_HOLD: begin
        if (redirect || consume) begin
          valid_d = 1'b0;
          state_d = S_REQ;
          if (take_irq)      fetch_pc_d = IRQ_VECTOR;
          else if (redirect) fetch_pc_d = redirect_addr;
        end
      end
      default: state_d = S_REQ;
    endcase
  end

endmodule

// File: tb/tb_cpu_fetchunit.sv
// Bench for cpu_fetchunit: directed scenarios followed by randomized traffic, all
// compared each cycle against an instruction-stream model of the fetch unit.
module tb_cpu_fetchunit;

  localparam logic [15:0] RV = 16'h0000;
  localparam logic [15:0] IV = 16'h0004;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [7:0]  imem_data;
  logic [7:0]  opcode;
  logic        opcode_valid;
  logic        opcode_ready;
  logic [15:0] pc;
  logic        redirect;
  logic [15:0] redirect_addr;
  logic        interrupt;
  logic        iret;
  logic        irq_ack;
  logic        irq_active;
  logic [15:0] epc;

  always #5 clk = ~clk;

  cpu_fetchunit #(.RESET_VECTOR(RV), .IRQ_VECTOR(IV)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
    .opcode(opcode), .opcode_valid(opcode_valid), .opcode_ready(opcode_ready), .pc(pc),
    .redirect(redirect), .redirect_addr(redirect_addr),
    .interrupt(interrupt), .iret(iret),
    .irq_ack(irq_ack), .irq_active(irq_active), .epc(epc)
  );

  int total = 0;
  int bad   = 0;

  // Model: what the control unit should see, derived from the instruction stream.
  logic        m_valid, m_req, dirty, m_irq_active, m_irq_ack;
  logic [15:0] m_pc, m_addr, exp_next, m_epc;
  logic [7:0]  m_op;
  int          wcnt = -1;
  int          lat_min = 0;
  int          lat_max = 0;

  function automatic logic [7:0] mem_byte(input logic [15:0] a);
    if (a == 16'h0000) return 8'h01;
    if (a == 16'h0001) return 8'h00;
    return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'hA5;
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%h required=%h t=%0t", nm, act, req, $time);
    end
  endtask

  task automatic check_all();
    chk("opcode_valid", 16'(opcode_valid), 16'(m_valid));
    chk("opcode", 16'(opcode), 16'(m_op));
    chk("pc", pc, m_pc);
    chk("imem_req", 16'(imem_req), 16'(m_req));
    if (m_req) chk("imem_addr", imem_addr, m_addr);
    chk("irq_ack", 16'(irq_ack), 16'(m_irq_ack));
    chk("irq_active", 16'(irq_active), 16'(m_irq_active));
    chk("epc", epc, m_epc);
  endtask

  task automatic step(input logic rdy, input logic rdr, input logic [15:0] ra,
                      input logic intr, input logic irt, input logic stale);
    logic ack_now, deliver, take, outstanding;
    ack_now = 1'b0;
    if (imem_req === 1'b1) begin
      if (wcnt < 0) wcnt = int'($urandom_range(lat_min, lat_max));
      if (wcnt == 0) begin
        ack_now = 1'b1;
        wcnt    = -1;
      end else begin
        wcnt--;
      end
    end else begin
      wcnt = -1;
    end
    if (stale) ack_now = 1'b1;
    imem_ack      = ack_now;
    imem_data     = ack_now ? mem_byte(imem_addr) : 8'($urandom);
    opcode_ready  = rdy;
    redirect      = rdr;
    redirect_addr = ra;
    interrupt     = intr;
    iret          = irt;

    deliver     = m_req && ack_now && !dirty && !rdr;
    outstanding = m_req && !ack_now;
    take        = 1'b0;
`ifdef CPU_FETCH_IRQ_EN
    take      = m_valid && (rdy || rdr) && intr && !m_irq_active;
    m_irq_ack = take;
    if (take) begin
      m_epc        = rdr ? ra : m_pc + 16'd1;
      m_irq_active = 1'b1;
    end else if (irt) begin
      m_irq_active = 1'b0;
    end
`endif
    if (take)                  exp_next = IV;
    else if (rdr)              exp_next = ra;
    else if (m_valid && rdy)   exp_next = m_pc + 16'd1;
    if (m_req && ack_now)      dirty = 1'b0;
    else if (m_req && rdr)     dirty = 1'b1;
    if (deliver) begin
      m_valid = 1'b1;
      m_pc    = m_addr;
      m_op    = mem_byte(m_addr);
    end else if (!(m_valid && !(rdy || rdr))) begin
      m_valid = 1'b0;
    end
    m_req = !m_valid;
    if (m_req && !outstanding) m_addr = exp_next;

    @(posedge clk); #1;
    check_all();
  endtask

  task automatic do_reset(input int n, input logic ack_in);
    reset = 1'b1;
    opcode_ready = 1'b0; redirect = 1'b0; redirect_addr = 16'h0000;
    interrupt = 1'b0; iret = 1'b0;
    imem_ack = ack_in; imem_data = 8'hEE;
    wcnt = -1;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      chk("rst_imem_req", 16'(imem_req), 16'h0000);
      chk("rst_pc", pc, RV);
      chk("rst_opcode", 16'(opcode), 16'h0000);
      chk("rst_valid", 16'(opcode_valid), 16'h0000);
      chk("rst_irq_ack", 16'(irq_ack), 16'h0000);
      chk("rst_irq_active", 16'(irq_active), 16'h0000);
      chk("rst_epc", epc, 16'h0000);
    end
    reset = 1'b0; imem_ack = 1'b0;
    m_valid = 1'b0; m_req = 1'b0; dirty = 1'b0;
    m_pc = RV; m_op = 8'h00; m_addr = RV; exp_next = RV;
    m_irq_active = 1'b0; m_irq_ack = 1'b0; m_epc = 16'h0000;
  endtask

  task automatic wait_valid(input string nm);
    int i;
    i = 0;
    while (opcode_valid !== 1'b1 && i < 20) begin
      step(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
      i++;
    end
    chk(nm, 16'(opcode_valid), 16'h0001);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; imem_ack = 1'b0; imem_data = 8'h00; opcode_ready = 1'b0;
    redirect = 1'b0; redirect_addr = 16'h0000; interrupt = 1'b0; iret = 1'b0;

    // Reset with a stray ack, then zero-wait streaming with ready held high.
    do_reset(3, 1'b1);
    step(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    chk("boot_addr", imem_addr, 16'h0000);
    step(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    chk("first_opcode", 16'(opcode), 16'h0001);
    chk("first_pc", pc, 16'h0000);
    step(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    chk("gap_valid", 16'(opcode_valid), 16'h0000);
    step(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    chk("second_opcode", 16'(opcode), 16'h0000);
    chk("second_pc", pc, 16'h0001);

    // Stall in HOLD for five cycles.
    repeat (5) step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    chk("stall_pc", pc, 16'h0001);
    chk("stall_req", 16'(imem_req), 16'h0000);
    step(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    chk("after_stall_addr", imem_addr, 16'h0002);

    // Redirect while a slow access is outstanding.
    lat_min = 3; lat_max = 3;
    step(1'b1, 1'b1, 16'h0040, 1'b0, 1'b0, 1'b0);
    chk("squash_old_addr", imem_addr, 16'h0002);
    wait_valid("redirect_delivery");
    chk("redirect_pc", pc, 16'h0040);
    chk("redirect_opcode", 16'(opcode), 16'h00E5);

    // Address wrap at the top of memory.
    lat_min = 0; lat_max = 0;
    step(1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0);
    wait_valid("wrap_delivery");
    chk("wrap_pc", pc, 16'hFFFF);
    step(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    chk("wrap_next_addr", imem_addr, 16'h0000);

    // Interrupt at the consume of pc 0x0010.
    wait_valid("pre_irq_delivery");
    step(1'b0, 1'b1, 16'h0010, 1'b0, 1'b0, 1'b0);
    wait_valid("irq_site_delivery");
    chk("irq_site_pc", pc, 16'h0010);
    step(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
`ifdef CPU_FETCH_IRQ_EN
    chk("irq_entry_ack", 16'(irq_ack), 16'h0001);
    chk("irq_entry_epc", epc, 16'h0011);
    chk("irq_entry_addr", imem_addr, 16'h0004);
    step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    chk("irq_ack_pulse", 16'(irq_ack), 16'h0000);
    wait_valid("handler_delivery");
    step(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    chk("nested_ignored", 16'(irq_ack), 16'h0000);
    step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
    chk("iret_clears", 16'(irq_active), 16'h0000);
`else
    chk("irq_disabled_ack", 16'(irq_ack), 16'h0000);
    chk("irq_disabled_active", 16'(irq_active), 16'h0000);
    chk("irq_disabled_addr", imem_addr, 16'h0011);
`endif

    // Randomized traffic.
    lat_min = 0; lat_max = 3;
    for (int i = 0; i < 3000; i++) begin
      logic [15:0] ra;
      ra = ($urandom_range(0, 3) == 0) ? 16'hFFFE : 16'($urandom);
      step(($urandom_range(0, 3) != 0), ($urandom_range(0, 11) == 0), ra,
           ($urandom_range(0, 5) == 0), ($urandom_range(0, 9) == 0), 1'b0);
    end

    // Reset in the middle of an outstanding access, ack landing during reset.
    lat_min = 3; lat_max = 3;
    for (int i = 0; i < 10 && imem_req !== 1'b1; i++)
      step(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    chk("pre_reset_req", 16'(imem_req), 16'h0001);
    step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    do_reset(2, 1'b1);
    lat_min = 0; lat_max = 0;
    step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    chk("rst2_first_req", 16'(imem_req), 16'h0001);
    chk("rst2_first_addr", imem_addr, RV);
    wait_valid("rst2_delivery");
    chk("rst2_opcode", 16'(opcode), 16'h0001);
    chk("rst2_pc", pc, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
